free_list_mw: RTL

- Multi-ported, checkpointable physical-register free list for the rename stage.
- Allocates up to DEQ_WIDTH physical registers (PRs) per cycle to rename and accepts up to ENQ_WIDTH freed PRs per cycle from retire.
- Saves head-pointer snapshots at branches and restores one on mispredict, which reclaims every PR allocated after that branch in a single cycle.
- Sits between the map table/rename logic and the ROB retire port.

---
 rtl/free_list_mw_if.sv | 38 +++
 rtl/free_list_mw.sv | 125 ++++++++++++
 2 files changed

// File: rtl/free_list_mw_if.sv
// Rename/retire-facing bundle of the multi-ported free list.
// The rename/retire side uses the master modport; the free list uses slave.
interface free_list_mw_if #(
    parameter int NUM_PREGS = 64,
    parameter int DEQ_WIDTH = 2,
    parameter int ENQ_WIDTH = 2,
    parameter int NUM_CKPT  = 4
);
    localparam int IDX = $clog2(NUM_PREGS);
    localparam int CNT = IDX + 1;
    localparam int CK  = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1;
    localparam int DW  = $clog2(DEQ_WIDTH + 1);

    logic [DW-1:0]                  deq_req;
    logic [DEQ_WIDTH-1:0][IDX-1:0]  deq_pr;
    logic [DW-1:0]                  deq_avail;
    logic [ENQ_WIDTH-1:0]           enq_valid;
    logic [ENQ_WIDTH-1:0][IDX-1:0]  enq_pr;
    logic                           ckpt_save;
    logic [CK-1:0]                  ckpt_save_id;
    logic                           rollback;
    logic [CK-1:0]                  rollback_id;
    logic [CNT-1:0]                 free_count;
    logic                           err_underflow;
    logic                           err_overflow;

    modport master (
        output deq_req, enq_valid, enq_pr, ckpt_save, ckpt_save_id,
               rollback, rollback_id,
        input  deq_pr, deq_avail, free_count, err_underflow, err_overflow
    );

    modport slave (
        input  deq_req, enq_valid, enq_pr, ckpt_save, ckpt_save_id,
               rollback, rollback_id,
        output deq_pr, deq_avail, free_count, err_underflow, err_overflow
    );
endinterface

// File: rtl/free_list_mw.sv
// Checkpointable multi-ported physical-register free list.
// Circular list with wrap-bit head/tail pointers; head snapshots taken at
// branches let a mispredict reclaim all younger allocations in one cycle.
module free_list_mw #(
    parameter int NUM_PREGS = 64,
    parameter int NUM_ARCH  = 32,
    parameter int DEQ_WIDTH = 2,
    parameter int ENQ_WIDTH = 2,
    parameter int NUM_CKPT  = 4
) (
    input  logic          clk,
    input  logic          reset,
    free_list_mw_if.slave fl
);
    localparam int IDX = $clog2(NUM_PREGS);
    localparam int CNT = IDX + 1;
    localparam int CK  = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1;
    localparam int DW  = $clog2(DEQ_WIDTH + 1);
    localparam int EW  = $clog2(ENQ_WIDTH + 1);

    // Multi-ported list storage: every deq_pr slot is a combinational read
    logic [IDX-1:0] list_mem [NUM_PREGS];

    logic [CNT-1:0] head_reg, head_next;
    logic [CNT-1:0] tail_reg, tail_next;
    logic [CNT-1:0] ckpt_reg [NUM_CKPT];
    logic           err_underflow_reg, err_overflow_reg;

    logic [CNT-1:0]       count;
    logic [DW-1:0]        avail;
    logic                 underflow;
    logic                 overflow;
    logic [ENQ_WIDTH-1:0] enq_ok;
    logic [EW-1:0]        enq_cnt;
    logic [IDX-1:0]       wr_idx [ENQ_WIDTH];
    logic [IDX-1:0]       rd_idx [DEQ_WIDTH];

    // Occupancy comes straight from the wrap-bit pointers
    assign count = tail_reg - head_reg;
    assign avail = (count >= CNT'(DEQ_WIDTH)) ? DW'(DEQ_WIDTH) : DW'(count);

    generate
        for (genvar gi = 0; gi < DEQ_WIDTH; gi++) begin : g_deq
            assign rd_idx[gi]    = head_reg[IDX-1:0] + IDX'(gi);
            assign fl.deq_pr[gi] = list_mem[rd_idx[gi]];
        end
        for (genvar gi = 0; gi < ENQ_WIDTH; gi++) begin : g_enq_ok
            // PR 0 is the hard-wired zero register and never re-enters the list
            assign enq_ok[gi] = fl.enq_valid[gi] && (fl.enq_pr[gi] != '0);
        end
    endgenerate

    // Compact accepted frees, detect over/underflow, compute next pointers
    always_comb begin
        enq_cnt = '0;
        for (int i = 0; i < ENQ_WIDTH; i++) begin
            wr_idx[i] = tail_reg[IDX-1:0] + IDX'(enq_cnt);
            if (enq_ok[i]) begin
                enq_cnt = enq_cnt + EW'(1);
            end
        end

        overflow  = ({1'b0, count} + (CNT+1)'(enq_cnt)) > (CNT+1)'(NUM_PREGS);
        tail_next = overflow ? tail_reg : tail_reg + CNT'(enq_cnt);

        // A rollback overrides this cycle's dequeue entirely
        underflow = !fl.rollback && (fl.deq_req > avail);
        if (fl.rollback) begin
            head_next = ckpt_reg[fl.rollback_id];
        end else if (underflow) begin
            head_next = head_reg;
        end else begin
            head_next = head_reg + CNT'(fl.deq_req);
        end
    end

    // Pointer and error-pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            head_reg          <= '0;
            tail_reg          <= CNT'(NUM_PREGS - NUM_ARCH);
            err_underflow_reg <= 1'b0;
            err_overflow_reg  <= 1'b0;
        end else begin
            head_reg          <= head_next;
            tail_reg          <= tail_next;
            err_underflow_reg <= underflow;
            err_overflow_reg  <= overflow;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CKPT; gi++) begin : g_ckpt
            // Snapshot the post-dequeue head so the branch's own PR stays allocated
            always_ff @(posedge clk) begin
                if (reset) begin
                    ckpt_reg[gi] <= '0;
                end else if (fl.ckpt_save && !fl.rollback &&
                             (fl.ckpt_save_id == CK'(gi))) begin
                    ckpt_reg[gi] <= head_next;
                end
            end
        end
    endgenerate

    // List contents: reset holds the unmapped PRs, frees are appended at tail
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_PREGS; k++) begin
                list_mem[k] <= (k < NUM_PREGS - NUM_ARCH) ? IDX'(NUM_ARCH + k) : '0;
            end
        end else if (!overflow) begin
            for (int i = 0; i < ENQ_WIDTH; i++) begin
                if (enq_ok[i]) begin
                    list_mem[wr_idx[i]] <= fl.enq_pr[i];
                end
            end
        end
    end

    assign fl.deq_avail     = avail;
    assign fl.free_count    = count;
    assign fl.err_underflow = err_underflow_reg;
    assign fl.err_overflow  = err_overflow_reg;
endmodule
